// File: rtl/lsu_mem_ctrl_if.sv
// Request/response handshake between the execute stage and the load/store controller.
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: one request at a time, alignment/range check, read-modify-write
// for sub-word stores, extended load data and a single response per request.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_mem_ctrl_if.slave     bus,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e              state_q, state_d;
  logic [1:0]          lane_q, lane_d;
  logic [1:0]          size_q, size_d;
  logic                we_q, we_d;
  logic                uns_q, uns_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_writedata_q, mem_writedata_d;
  logic                mem_memwrite_q, mem_memwrite_d;
  logic                mem_memread_q, mem_memread_d;

  function automatic logic req_bad(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'b11) ||
           (size == 2'b01 && addr[0]) ||
           (size == 2'b10 && addr[1:0] != 2'b00) ||
           (addr[31:ADDR_W] != '0);
  endfunction

  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [1:0] lane,
                                                    input logic [1:0] size,
                                                    input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return uns ? {24'h0, b} : DATA_W'(b);
      2'b01:   return uns ? {16'h0, h} : DATA_W'(h);
      default: return word;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] word,
                                                    input logic [DATA_W-1:0] wdata,
                                                    input logic [1:0] lane,
                                                    input logic [1:0] size);
    logic [DATA_W-1:0] m;
    m = word;
    if (size == 2'b00) begin
      m[{lane, 3'b000} +: 8] = wdata[7:0];
    end else if (lane[1]) begin
      m[31:16] = wdata[15:0];
    end else begin
      m[15:0] = wdata[15:0];
    end
    return m;
  endfunction

  always_comb begin
    state_d         = state_q;
    lane_d          = lane_q;
    size_d          = size_q;
    we_d            = we_q;
    uns_d           = uns_q;
    wdata_d         = wdata_q;
    resp_valid_d    = resp_valid_q;
    resp_err_d      = resp_err_q;
    resp_rdata_d    = resp_rdata_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    mem_memwrite_d  = 1'b0;
    mem_memread_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          lane_d  = bus.req_addr[1:0];
          size_d  = bus.req_size;
          we_d    = bus.req_we;
          uns_d   = bus.req_unsigned;
          wdata_d = bus.req_wdata;
          if (req_bad(bus.req_size, bus.req_addr)) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (!bus.req_we || bus.req_size != 2'b10) begin
            state_d       = RD;
            mem_memread_d = 1'b1;
            mem_address_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
          end else begin
            state_d         = WR;
            mem_memwrite_d  = 1'b1;
            mem_address_d   = {bus.req_addr[ADDR_W-1:2], 2'b00};
            mem_writedata_d = bus.req_wdata;
          end
        end
      end
      // mem_readdata is valid at the edge that ends RD
      RD: begin
        if (we_q) begin
          state_d         = WR;
          mem_memwrite_d  = 1'b1;
          mem_writedata_d = store_merge(mem_readdata, wdata_q, lane_q, size_q);
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = load_extend(mem_readdata, lane_q, size_q, uns_q);
        end
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      req_ready_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_err_q      <= 1'b0;
      resp_rdata_q    <= '0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      mem_memwrite_q  <= 1'b0;
      mem_memread_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_err_q      <= resp_err_d;
      resp_rdata_q    <= resp_rdata_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      mem_memwrite_q  <= mem_memwrite_d;
      mem_memread_q   <= mem_memread_d;
    end
  end

  // Captured request fields are only read in RD, so they need no reset
  always_ff @(posedge clk) begin
    lane_q  <= lane_d;
    size_q  <= size_d;
    we_q    <= we_d;
    uns_q   <= uns_d;
    wdata_q <= wdata_d;
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign mem_address    = mem_address_q;
  assign mem_writedata  = mem_writedata_q;
  assign mem_memwrite   = mem_memwrite_q;
  assign mem_memread    = mem_memread_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl with a behavioural word memory.
module tb_lsu_mem_ctrl;
  localparam int ADDR_W = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if bus();

  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata = '0;
  logic              mem_memwrite;
  logic              mem_memread;

  lsu_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_memwrite (mem_memwrite),
    .mem_memread  (mem_memread),
    .mem_readdata (mem_readdata)
  );

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mem [32];
  int          cyc = 0, rd_cnt = 0, wr_cnt = 0, overlap = 0;
  logic [ADDR_W-1:0] rd_addr = '0;
  int          checks = 0, failures = 0;
  logic        seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory: writes commit at the rising edge, reads update on the falling edge
  always @(posedge clk) begin
    cyc++;
    if (mem_memread) begin
      rd_cnt++;
      rd_addr = mem_address;
    end
    if (mem_memwrite) begin
      wr_cnt++;
      mem[mem_address[ADDR_W-1:2]] = mem_writedata;
    end
    if (mem_memread && mem_memwrite) overlap++;
  end

  always @(negedge clk) begin
    if (mem_memread) mem_readdata = mem[mem_address[ADDR_W-1:2]];
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      seen = 1'b0;
    end else if (bus.resp_valid && !seen) begin
      seen = 1'b1;
      if (sbq.size() == 0) begin
        chk("unexpected_resp", 32'(bus.resp_valid), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk({e.tag, "_rdata"}, bus.resp_rdata, e.rdata);
        chk({e.tag, "_err"}, 32'(bus.resp_err), 32'(e.err));
        chk({e.tag, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end else if (!bus.resp_valid) begin
      seen = 1'b0;
    end
  end

  task automatic do_req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input int lat);
    int   n;
    exp_t e;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    n = 0;
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk({tag, "_accept_timeout"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
    end else begin
      e.tag = tag; e.rdata = er; e.err = ee; e.acc = cyc + 1; e.lat = lat;
      sbq.push_back(e);
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((sbq.size() != 0 || bus.resp_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0, n;
    logic [31:0] old;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[0] = 32'h0000_0005;
    mem[1] = 32'h0000_F080;
    mem[2] = 32'h1122_3344;
    mem[3] = 32'h1234_5678;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_memread", 32'(mem_memread), 32'd0);
    chk("rst_memwrite", 32'(mem_memwrite), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_mem_writedata", mem_writedata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

    r0 = rd_cnt;
    do_req("ld_w0", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0000_0005, 1'b0, 2);
    wait_done("ld_w0");
    chk("ld_w0_rdcnt", 32'(rd_cnt - r0), 32'd1);
    chk("ld_w0_addr", 32'(rd_addr), 32'd0);

    do_req("ld_b4s", 1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
    do_req("ld_b4u", 1'b0, 2'b00, 1'b1, 32'h4, 32'h0, 32'h0000_0080, 1'b0, 2);
    do_req("ld_h4s", 1'b0, 2'b01, 1'b0, 32'h4, 32'h0, 32'hFFFF_F080, 1'b0, 2);
    do_req("ld_h4u", 1'b0, 2'b01, 1'b1, 32'h4, 32'h0, 32'h0000_F080, 1'b0, 2);
    do_req("ld_b5s", 1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 32'hFFFF_FFF0, 1'b0, 2);
    wait_done("ld_w1");
    chk("ld_w1_addr", 32'(rd_addr), 32'd4);

    r0 = rd_cnt; w0 = wr_cnt;
    do_req("st_b9", 1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_00AA, 32'h0, 1'b0, 3);
    wait_done("st_b9");
    chk("st_b9_mem", mem[2], 32'h1122_AA44);
    chk("st_b9_rdcnt", 32'(rd_cnt - r0), 32'd1);
    chk("st_b9_wrcnt", 32'(wr_cnt - w0), 32'd1);

    do_req("st_hA", 1'b1, 2'b01, 1'b0, 32'hA, 32'h1234_BEEF, 32'h0, 1'b0, 3);
    wait_done("st_hA");
    chk("st_hA_mem", mem[2], 32'hBEEF_AA44);
    do_req("ld_bBs", 1'b0, 2'b00, 1'b0, 32'hB, 32'h0, 32'hFFFF_FFBE, 1'b0, 2);
    do_req("ld_hAu", 1'b0, 2'b01, 1'b1, 32'hA, 32'h0, 32'h0000_BEEF, 1'b0, 2);
    wait_done("ld_w2");

    r0 = rd_cnt; w0 = wr_cnt;
    do_req("st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFE_F00D, 32'h0, 1'b0, 2);
    wait_done("st_w10");
    chk("st_w10_mem", mem[4], 32'hCAFE_F00D);
    chk("st_w10_rdcnt", 32'(rd_cnt - r0), 32'd0);
    chk("st_w10_wrcnt", 32'(wr_cnt - w0), 32'd1);
    do_req("ld_w10", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'hCAFE_F00D, 1'b0, 2);
    wait_done("ld_w10");

    r0 = rd_cnt; w0 = wr_cnt;
    do_req("err_w2", 1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1, 1);
    do_req("err_h5", 1'b0, 2'b01, 1'b0, 32'h5, 32'h0, 32'h0, 1'b1, 1);
    do_req("err_sz", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1);
    do_req("err_rng", 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 32'h0, 1'b1, 1);
    do_req("err_strng", 1'b1, 2'b00, 1'b0, 32'h8000_0000, 32'hFF, 32'h0, 1'b1, 1);
    wait_done("err");
    chk("err_rdcnt", 32'(rd_cnt - r0), 32'd0);
    chk("err_wrcnt", 32'(wr_cnt - w0), 32'd0);

    bus.resp_ready = 1'b0;
    r0 = rd_cnt;
    do_req("hold_ld", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0000_F080, 1'b0, 2);
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_valid_seen", 32'(bus.resp_valid), 32'd1);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_rdata", bus.resp_rdata, 32'h0000_F080);
      chk("hold_err", 32'(bus.resp_err), 32'd0);
      chk("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    chk("hold_rdcnt", 32'(rd_cnt - r0), 32'd1);
    bus.resp_ready = 1'b1;
    do_req("after_hold", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0000_0005, 1'b0, 2);
    wait_done("after_hold");
    chk("after_hold_rdcnt", 32'(rd_cnt - r0), 32'd2);

    w0 = wr_cnt; old = mem[3];
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
    bus.req_addr = 32'hC; bus.req_wdata = 32'hDEAD_BEEF;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rstwr_memwrite_on", 32'(mem_memwrite), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rstwr_memwrite_drop", 32'(mem_memwrite), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstwr_mem", mem[3], old);
    chk("rstwr_wrcnt", 32'(wr_cnt - w0), 32'd0);
    @(negedge clk);
    chk("rstwr_ready", 32'(bus.req_ready), 32'd1);
    chk("rstwr_resp_valid", 32'(bus.resp_valid), 32'd0);
    do_req("ld_w3", 1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 32'h1234_5678, 1'b0, 2);
    wait_done("ld_w3");

    chk("no_rd_wr_overlap", 32'(overlap), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store controller between the execute stage and the data memory. It accepts one load or store request at a time over a valid/ready handshake and checks alignment and range. It drives the data memory's word-indexed port, doing a read-modify-write for byte and halfword stores. Load data is returned sign- or zero-extended, and every request, store or load, gets one response over a valid/ready handshake.

Parameters:
ADDR_W, 7, byte-address width of the data memory; memory word index is mem_address[ADDR_W-1:2].
DATA_W, 32, data width. Fixed at 32; other values are unsupported.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request.
req_we  in  1  1=store, 0=load.
req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
resp_valid  out  1  response present.
resp_ready  in  1  consumer takes the response.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  1  request rejected (misaligned, illegal size or out of range).
mem_address  out  ADDR_W  to memory; bits [1:0] always 00.
mem_writedata  out  32  to memory.
mem_memwrite  out  1  memory write enable, committed at rising edge.
mem_memread  out  1  memory read enable; memory updates readdata on the falling edge of the same cycle.
mem_readdata  in  32  from memory; valid at the rising edge ending a memread cycle.

Behaviour:
- States: IDLE, RD, WR, RESP. All state, captured request fields and outputs are registered or decoded from state only.
- Reset (async, rst_n=0): state=IDLE; req_ready=0 while in reset; resp_valid=0, resp_rdata=0, resp_err=0; mem_memwrite=0, mem_memread=0, mem_address=0, mem_writedata=0.
- A write in flight when reset asserts is abandoned; mem_memwrite drops immediately.
- req_ready=1 only in IDLE (out of reset). Accept on a rising edge with req_valid&req_ready, capturing addr, size, we, unsigned and wdata.
- Error check at accept:
  - req_size=11 → error.
  - Half with addr[0]=1 → error.
  - Word with addr[1:0]≠0 → error.
  - Any nonzero bit in req_addr[31:ADDR_W] → error.
  - Error path: IDLE→RESP with resp_err=1, rdata=0. No memory access.
- Load: IDLE→RD.
  - In RD: mem_memread=1, mem_address={addr[ADDR_W-1:2],2'b00}.
  - At the edge ending RD: extract the lane (byte lane addr[1:0], half lane addr[1]), extend per req_unsigned, register into resp_rdata, go to RESP.
  - Latency: resp_valid rises 2 cycles after the accept edge.
- Word store: IDLE→WR.
  - In WR: mem_memwrite=1, mem_writedata=wdata.
  - Then →RESP, resp_rdata=0. resp_valid rises 2 cycles after accept.
- Byte/half store: IDLE→RD→WR→RESP.
  - In RD, read the word.
  - In WR, write that word with only the addressed lane replaced by wdata[7:0] or wdata[15:0].
  - resp_valid rises 3 cycles after accept.
- mem_memread and mem_memwrite are never both 1, and are 0 in IDLE and RESP.
- RESP: hold resp_valid, resp_rdata and resp_err stable until resp_ready=1. On that edge →IDLE and clear resp_valid. A new request is accepted no earlier than the following edge (at most one outstanding request).
- req_* inputs are ignored outside IDLE. Back-pressure via resp_ready never causes a repeat memory access.

Test Plan:
- Memory word0=0x00000005; load word addr 0x0, resp_ready=1 → memread for 1 cycle at mem_address=0; resp_valid 2 cycles after accept; rdata=0x00000005, err=0.
- Word1=0x0000F080; load byte addr 0x4, signed → rdata=0xFFFFFF80. Unsigned → 0x00000080. Half addr 0x4, signed → 0xFFFFF080.
- Word2=0x11223344; store byte 0xAA to addr 0x9 → RD then WR; memory word2=0x1122AA44; resp 3 cycles after accept, rdata=0.
- Misaligned word addr 0x2, half addr 0x5, size=11, and addr 0x80 → resp_err=1 one cycle after accept; memread and memwrite never asserted.
- Load held with resp_ready=0 for 5 cycles → resp outputs stable, req_ready=0, memread asserted exactly once. A second req_valid during the hold is not accepted until after the resp handshake.
- Assert rst_n=0 during WR of a word store → mem_memwrite drops immediately and the memory word is unchanged; after release, state is IDLE, req_ready=1, resp_valid=0.
